// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source completion FIFOs, round-robin broadcast.
// Optional same-cycle bypass when every FIFO is empty: define CDB_BYPASS_EN.
package cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  Tag;
        logic [31:0] Value;
        logic [31:0] alu_result;
        logic        take_branch;
        logic [31:0] NPC;
        logic [31:0] PC;
        logic [31:0] inst;
        logic        halt;
        logic        illegal;
    } CDB_PACKET;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash_signal,
    input  logic                       Branch_Miss,
    input  CDB_PACKET                  fu_packet_in [NUM_SRC],
    output logic [NUM_SRC-1:0]         fu_ready,
    output CDB_PACKET                  CDB_packet_out,
    output logic [$clog2(NUM_SRC)-1:0] grant_src
);
    localparam int SW = $clog2(NUM_SRC);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    CDB_PACKET          mem   [NUM_SRC][BUF_DEPTH];
    logic [PW-1:0]      head  [NUM_SRC];
    logic [PW-1:0]      tail  [NUM_SRC];
    logic [CW-1:0]      count [NUM_SRC];
    logic [SW-1:0]      rr_ptr;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               found;
    logic               bypass;
    logic               flush;
    logic [SW-1:0]      win;
    logic [SW-1:0]      idx;
    CDB_PACKET          win_pkt;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign flush = squash_signal | Branch_Miss;

    always_comb begin
        fu_ready = '0;
        req      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            fu_ready[i] = count[i] < CW'(BUF_DEPTH);
            req[i]      = count[i] != '0;
        end
    end

    always_comb begin
        bypass = 1'b0;
        cand   = req;
`ifdef CDB_BYPASS_EN
        // With nothing buffered, the inputs themselves compete for the bus.
        if (req == '0) begin
            bypass = 1'b1;
            for (int i = 0; i < NUM_SRC; i++)
                cand[i] = fu_packet_in[i].valid;
        end
`endif
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = SW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_pkt       = bypass ? fu_packet_in[win] : mem[win][head[win]];
        win_pkt.valid = 1'b1;
        push = '0;
        pop  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]  = found && !bypass && (win == SW'(i));
            push[i] = fu_packet_in[i].valid && fu_ready[i]
                      && !(bypass && found && (win == SW'(i)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            rr_ptr         <= '0;
            CDB_packet_out <= '0;
            grant_src      <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (push[i])
                    tail[i] <= bump(tail[i]);
                if (pop[i])
                    head[i] <= bump(head[i]);
                if (push[i] && !pop[i])
                    count[i] <= count[i] + CW'(1);
                else if (pop[i] && !push[i])
                    count[i] <= count[i] - CW'(1);
            end
            if (found) begin
                CDB_packet_out <= win_pkt;
                grant_src      <= win;
                rr_ptr <= (win == SW'(NUM_SRC - 1)) ? '0 : win + SW'(1);
            end else begin
                CDB_packet_out <= '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SRC; i++)
            if (push[i] && !reset && !flush)
                mem[i][tail[i]] <= fu_packet_in[i];
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand sequences, random vs queue model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash_signal;
    logic        Branch_Miss;
    CDB_PACKET   pin [4];
    logic [3:0]  fu_ready;
    CDB_PACKET   CDB_packet_out;
    logic [1:0]  grant_src;

    int ncmp = 0;
    int nerr = 0;

    CDB_PACKET   mq [4][$];
    int          rr;
    CDB_PACKET   eo;
    logic [1:0]  eg;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [3:0] v;
        logic [3:0] er;
        logic       ev;
        logic [1:0] eg;
    } vec_t;
    vec_t tbl [19];

    cdb_arbiter #(.NUM_SRC(4), .BUF_DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .squash_signal  (squash_signal),
        .Branch_Miss    (Branch_Miss),
        .fu_packet_in   (pin),
        .fu_ready       (fu_ready),
        .CDB_packet_out (CDB_packet_out),
        .grant_src      (grant_src)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic CDB_PACKET fixed_pkt(input int s);
        CDB_PACKET p;
        p             = '0;
        p.valid       = 1'b1;
        p.Tag         = 6'(s + 4);
        p.Value       = 32'hDEAD_BEEE + 32'(s);
        p.alu_result  = 32'h1000 + 32'(s);
        p.take_branch = s[0];
        p.NPC         = 32'h100 * 32'(s) + 32'h4;
        p.PC          = 32'h100 * 32'(s);
        p.inst        = 32'h13 | (32'(s) << 7);
        p.halt        = (s == 3);
        p.illegal     = (s == 2);
        return p;
    endfunction

    function automatic CDB_PACKET rand_pkt();
        CDB_PACKET p;
        p             = '0;
        p.valid       = 1'b1;
        p.Tag         = 6'($urandom);
        p.Value       = $urandom;
        p.alu_result  = $urandom;
        p.take_branch = 1'($urandom);
        p.NPC         = $urandom;
        p.PC          = $urandom;
        p.inst        = $urandom;
        p.halt        = 1'($urandom);
        p.illegal     = 1'($urandom);
        return p;
    endfunction

    // One clock: check ready, advance the queue model, check the broadcast.
    task automatic tick();
        logic [3:0] er;
        int         g;
        logic       rst_now;
        #1;
        for (int i = 0; i < 4; i++)
            er[i] = mq[i].size() < 2;
        chk("fu_ready", 256'(fu_ready), 256'(er));
        rst_now = reset;
        if (reset || squash_signal || Branch_Miss) begin
            for (int i = 0; i < 4; i++)
                mq[i].delete();
            rr = 0;
            eo = '0;
            eg = 2'd0;
        end else begin
            g = -1;
            for (int k = 0; k < 4; k++)
                if (g < 0 && mq[(rr + k) % 4].size() > 0)
                    g = (rr + k) % 4;
            if (g >= 0) begin
                eo       = mq[g].pop_front();
                eo.valid = 1'b1;
                eg       = 2'(g);
                rr       = (g + 1) % 4;
            end else begin
                eo = '0;
            end
            for (int i = 0; i < 4; i++)
                if (pin[i].valid && er[i])
                    mq[i].push_back(pin[i]);
        end
        @(posedge clock);
        #1;
        chk("cdb_out", 256'(CDB_packet_out), 256'(eo));
        if (eo.valid || rst_now)
            chk("grant_src", 256'(grant_src), 256'(eg));
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 4; i++)
            pin[i] = '0;
        reset         = 1'b0;
        squash_signal = 1'b0;
        Branch_Miss   = 1'b0;
    endtask

    initial begin
        int last2;
        int maxgap;
        logic saw_nr2;

        tbl[0]  = '{1'b0, 1'b0, 4'b0010, 4'b1111, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd1};
        tbl[2]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
        tbl[3]  = '{1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd0};
        tbl[6]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd2};
        tbl[8]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 2'd3};
        tbl[9]  = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 1'b0, 4'b0001, 4'b1111, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 4'b1001, 4'b1111, 1'b1, 2'd0};
        tbl[12] = '{1'b0, 1'b0, 4'b0001, 4'b1111, 1'b1, 2'd3};
        tbl[13] = '{1'b0, 1'b1, 4'b0000, 4'b1110, 1'b0, 2'd0};
        tbl[14] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};
        tbl[15] = '{1'b0, 1'b0, 4'b0100, 4'b1111, 1'b0, 2'd0};
        tbl[16] = '{1'b0, 1'b0, 4'b0110, 4'b1111, 1'b1, 2'd2};
        tbl[17] = '{1'b1, 1'b0, 4'b1111, 4'b1111, 1'b0, 2'd0};
        tbl[18] = '{1'b0, 1'b0, 4'b0000, 4'b1111, 1'b0, 2'd0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_out", 256'(CDB_packet_out), 256'(0));
        chk("reset_grant", 256'(grant_src), 256'(0));
        chk("reset_ready", 256'(fu_ready), 256'(4'b1111));
        for (int i = 0; i < 4; i++)
            mq[i].delete();
        rr = 0;
        eo = '0;
        eg = 2'd0;
        reset = 1'b0;

        for (int r = 0; r < 19; r++) begin
            for (int i = 0; i < 4; i++) begin
                pin[i]       = fixed_pkt(i);
                pin[i].valid = tbl[r].v[i];
            end
            reset       = tbl[r].rst;
            Branch_Miss = tbl[r].fl;
            #1;
            chk("tbl_ready", 256'(fu_ready), 256'(tbl[r].er));
            tick();
            chk("tbl_valid", 256'(CDB_packet_out.valid), 256'(tbl[r].ev));
            if (tbl[r].ev) begin
                chk("tbl_grant", 256'(grant_src), 256'(tbl[r].eg));
                chk("tbl_payload", 256'(CDB_packet_out),
                    256'(fixed_pkt(int'(tbl[r].eg))));
            end
        end
        idle_inputs();

        // src2 held for 5 cycles while src0 requests every cycle
        last2   = -1;
        maxgap  = 0;
        saw_nr2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            pin[0] = rand_pkt();
            pin[2] = '0;
            if (c < 5)
                pin[2] = rand_pkt();
            #1;
            if (!fu_ready[2])
                saw_nr2 = 1'b1;
            tick();
            if (CDB_packet_out.valid && grant_src == 2'd2) begin
                if (last2 >= 0 && c - last2 > maxgap)
                    maxgap = c - last2;
                last2 = c;
            end
        end
        chk("bp_not_ready2", 256'(saw_nr2), 256'(1));
        chk("bp_gap_le4", 256'(maxgap <= 4 && maxgap > 0), 256'(1));
        idle_inputs();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                pin[i] = '0;
                if ($urandom_range(99) < 65)
                    pin[i] = rand_pkt();
            end
            reset         = ($urandom_range(199) == 0);
            squash_signal = ($urandom_range(59) == 0);
            Branch_Miss   = ($urandom_range(59) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
